// File: rtl/gpr_file_clr.sv
// gpr_file_clr: parametrised picoMIPS register file with an optional hardwired
// zero register 0, write-first bypass on both read ports and a one-entry-per-cycle
// bulk-clear sequencer reported through busy / wr_err.
module gpr_file_clr #(
    parameter int N       = 8,
    parameter int A       = 5,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         w,
    input  logic [N-1:0] Wdata,
    input  logic [A-1:0] Rdno,
    input  logic [A-1:0] Rsno,
    input  logic         clr,
    output logic [N-1:0] Rd,
    output logic [N-1:0] Rs,
    output logic         busy,
    output logic         wr_err
);

    localparam int unsigned DEPTH = 1 << A;
    localparam logic [A-1:0] FIRST = ZERO_R0 ? A'(1) : '0;
    localparam logic [A-1:0] LAST  = '1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t       state, state_n;
    logic [A-1:0] ptr, ptr_n;
    logic         busy_n;
    logic         accept;
    logic [N-1:0] gpr [DEPTH];

    // Writes are blocked while sweeping and never touch a hardwired register 0.
    assign accept = w && !busy && !(ZERO_R0 && (Rdno == '0));

    // Next-state logic for the bulk-clear sequencer; clr is ignored once sweeping.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_n = CLEAR;
                    ptr_n   = FIRST;
                    busy_n  = 1'b1;
                end
            end
            CLEAR: begin
                if (ptr == LAST) begin
                    state_n = IDLE;
                    ptr_n   = FIRST;
                    busy_n  = 1'b0;
                end else begin
                    ptr_n = ptr + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = FIRST;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Sequencer registers; wr_err flags any write attempted while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= FIRST;
            busy   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            busy   <= busy_n;
            wr_err <= w && busy;
        end
    end

    // Storage: sweep clears the entry at ptr, otherwise an accepted write lands.
    // busy mirrors the CLEAR state, so the two branches never compete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                gpr[i] <= '0;
            end
        end else if (state == CLEAR) begin
            gpr[ptr] <= '0;
        end else if (accept) begin
            gpr[Rdno] <= Wdata;
        end
    end

    // Rd read port: zero register, then same-cycle bypass, then array.
    always_comb begin
        Rd = gpr[Rdno];
        if (ZERO_R0 && (Rdno == '0)) begin
            Rd = '0;
        end else if (accept) begin
            Rd = Wdata;
        end
    end

    // Rs read port: zero register, then bypass when it aliases Rdno, then array.
    always_comb begin
        Rs = gpr[Rsno];
        if (ZERO_R0 && (Rsno == '0)) begin
            Rs = '0;
        end else if (accept && (Rsno == Rdno)) begin
            Rs = Wdata;
        end
    end

endmodule

// File: tb/tb_gpr_file_clr.sv
// Scoreboard bench for gpr_file_clr: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_gpr_file_clr;

    logic        clk;
    logic        reset;
    int          cyc;

    // 8-bit, 32-entry, hardwired-zero instance
    logic        w, clr, busy, wr_err;
    logic [7:0]  wdata, rd, rs;
    logic [4:0]  rdno, rsno;

    // 16-bit, 8-entry, ordinary-r0 instance
    logic        w2, clr2, busy2, wr_err2;
    logic [15:0] wdata2, rd2, rs2;
    logic [2:0]  rdno2, rsno2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];

    gpr_file_clr #(.N(8), .A(5), .ZERO_R0(1'b1)) dut8 (
        .clk(clk), .reset(reset), .w(w), .Wdata(wdata), .Rdno(rdno), .Rsno(rsno),
        .clr(clr), .Rd(rd), .Rs(rs), .busy(busy), .wr_err(wr_err)
    );

    gpr_file_clr #(.N(16), .A(3), .ZERO_R0(1'b0)) dut16 (
        .clk(clk), .reset(reset), .w(w2), .Wdata(wdata2), .Rdno(rdno2), .Rsno(rsno2),
        .clr(clr2), .Rd(rd2), .Rs(rs2), .busy(busy2), .wr_err(wr_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            0: actual = {8'h00, rd};
            1: actual = {8'h00, rs};
            2: actual = {15'h0, busy};
            3: actual = {15'h0, wr_err};
            4: actual = rd2;
            5: actual = rs2;
            6: actual = {15'h0, busy2};
            default: actual = 16'hxxxx;
        endcase
    endfunction

    task automatic chk(input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due this cycle away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic [15:0] a;
                e = q.pop_front();
                a = actual(e.sel);
                checks++;
                if (e.cyc != cyc) begin
                    failures++;
                    $display("FAIL %s: stale expectation cycle %0d seen at %0d", e.name, e.cyc, cyc);
                end else if (a !== e.exp) begin
                    failures++;
                    $display("FAIL %s: cycle %0d actual=%h required=%h", e.name, cyc, a, e.exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        w = 0; clr = 0; wdata = '0; rdno = '0; rsno = '0;
        w2 = 0; clr2 = 0; wdata2 = '0; rdno2 = '0; rsno2 = '0;

        // Reset state
        tick();
        rsno = 5'd3; rdno = 5'd3;
        chk(2, 0, "rst_busy"); chk(3, 0, "rst_wr_err"); chk(1, 0, "rst_rs"); chk(6, 0, "rst_busy16");
        tick();
        reset = 1'b1;
        tick();

        // 1: write-first bypass, then array read
        w = 1; rdno = 5'd3; wdata = 8'hA5; rsno = 5'd3;
        chk(0, 16'h00A5, "t1_rd_bypass"); chk(1, 16'h00A5, "t1_rs_bypass");
        tick();
        w = 0; rsno = 5'd4;
        chk(0, 16'h00A5, "t1_rd_array"); chk(1, 16'h0000, "t1_rs_other");
        tick();

        // 2: hardwired r0
        w = 1; rdno = 5'd0; wdata = 8'hFF; rsno = 5'd0;
        chk(0, 0, "t2_rd_r0_now"); chk(1, 0, "t2_rs_r0_now");
        tick();
        w = 0;
        chk(0, 0, "t2_rd_r0_after"); chk(1, 0, "t2_rs_r0_after"); chk(3, 0, "t2_wr_err");
        tick();

        // 3: fill r1..r31 with their index and sweep
        for (int i = 1; i < 32; i++) begin
            w = 1; rdno = 5'(i); wdata = 8'(i);
            tick();
        end
        w = 0; clr = 1; rsno = 5'd31;
        chk(2, 0, "t3_busy_before");
        tick();
        clr = 0;
        for (int k = 0; k < 31; k++) begin
            chk(2, 1, "t3_busy");
            chk(1, 16'd31, "t3_rs31_unswept");
            if ((k % 2) == 0) begin
                rdno = 5'(k + 1);
                chk(0, 16'(k + 1), "t3_rd_unswept");
            end else begin
                rdno = 5'(k);
                chk(0, 0, "t3_rd_swept");
            end
            tick();
        end
        chk(2, 0, "t3_busy_fall"); chk(1, 0, "t3_rs31_cleared");
        tick();
        for (int i = 0; i < 32; i++) begin
            rsno = 5'(i);
            chk(1, 0, "t3_all_zero");
            tick();
        end

        // 4: writes dropped during a sweep; clr held is ignored
        w = 1; rdno = 5'd5; wdata = 8'h55;
        tick();
        w = 0; clr = 1;
        tick();
        for (int k = 0; k < 31; k++) begin
            if (k == 4) clr = 0;
            chk(2, 1, "t4_busy");
            if (k == 2 || k == 3) begin
                w = 1; rdno = 5'd5; wdata = 8'h3C; rsno = 5'd5;
            end else begin
                w = 0;
            end
            if (k == 2) begin
                chk(0, 16'h0055, "t4_rd_no_bypass"); chk(1, 16'h0055, "t4_rs_no_bypass");
                chk(3, 0, "t4_wr_err_pre");
            end
            if (k == 3) chk(3, 1, "t4_wr_err_first");
            if (k == 4) begin
                chk(3, 1, "t4_wr_err_hold"); chk(1, 16'h0055, "t4_r5_unswept");
            end
            if (k == 5) begin
                chk(3, 0, "t4_wr_err_clear"); chk(1, 0, "t4_r5_swept");
            end
            tick();
        end
        chk(2, 0, "t4_busy_fall"); chk(1, 0, "t4_r5_zero");
        tick();

        // 5: reset aborts a sweep, then a fresh full sweep
        w = 1; rdno = 5'd20; wdata = 8'h77;
        tick();
        w = 0; clr = 1; rsno = 5'd20;
        tick();
        clr = 0;
        for (int k = 0; k < 10; k++) begin
            chk(2, 1, "t5_busy_pre");
            if (k == 9) chk(1, 16'h0077, "t5_r20_before");
            tick();
        end
        reset = 1'b0;
        chk(2, 0, "t5_busy_abort"); chk(1, 0, "t5_r20_reset");
        tick();
        reset = 1'b1;
        chk(2, 0, "t5_busy_released");
        tick();
        clr = 1;
        tick();
        clr = 0;
        for (int k = 0; k < 31; k++) begin
            chk(2, 1, "t5_busy_full");
            tick();
        end
        chk(2, 0, "t5_busy_fall");
        tick();

        // 6: 16-bit, 8-entry, r0 ordinary
        w2 = 1; rdno2 = 3'd0; wdata2 = 16'hBEEF; rsno2 = 3'd0;
        chk(5, 16'hBEEF, "t6_rs_bypass");
        tick();
        w2 = 0;
        chk(4, 16'hBEEF, "t6_rd_r0"); chk(5, 16'hBEEF, "t6_rs_r0");
        tick();
        w2 = 1; rdno2 = 3'd7; wdata2 = 16'h1234;
        tick();
        w2 = 0; rsno2 = 3'd7;
        chk(5, 16'h1234, "t6_r7");
        clr2 = 1;
        tick();
        clr2 = 0;
        for (int k = 0; k < 8; k++) begin
            chk(6, 1, "t6_busy");
            tick();
        end
        chk(6, 0, "t6_busy_fall");
        tick();
        for (int i = 0; i < 8; i++) begin
            rsno2 = 3'(i); rdno2 = 3'(7 - i);
            chk(5, 0, "t6_rs_zero"); chk(4, 0, "t6_rd_zero");
            tick();
        end

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
